// File: rtl/palette_loader.sv
// Palette file download parser: skips a header, packs R,G,B byte
// triplets into 15-bit colour words and writes them to palette RAM.
module palette_loader #(
    parameter int HDR_BYTES = 0,
    parameter int ENTRIES   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dl_active,
    input  logic        dl_wr,
    input  logic [7:0]  dl_data,
    output logic        load_color,
    output logic [14:0] load_color_data,
    output logic [5:0]  load_color_index,
    output logic        busy,
    output logic        pal_valid,
    output logic        err_short
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SKIP  = 2'd1;
    localparam logic [1:0] S_RECV  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam bit         HAS_HDR   = (HDR_BYTES > 0);
    localparam logic [7:0] HDR_LAST  = 8'(HDR_BYTES - 1);
    localparam logic [6:0] ENT_LAST  = 7'(ENTRIES - 1);
    localparam logic [6:0] ENT_FULL  = 7'(ENTRIES);

    logic [1:0] state;
    logic [1:0] phase;
    logic [6:0] entry_cnt;
    logic [7:0] hdr_cnt;
    logic [7:0] red_q;
    logic [7:0] grn_q;
    logic       act_q;
    logic       armed;

    logic       rise;
    logic       fall;
    logic       wr_fire;
    logic [6:0] cnt_n;

    // Edge detection and the byte that completes an entry this cycle.
    // armed stays low after reset until dl_active is seen low, so a
    // download still in progress across reset is not picked up again.
    always_comb begin
        rise    = dl_active & ~act_q & armed;
        fall    = ~dl_active & act_q;
        wr_fire = (state == S_RECV) && dl_wr && (phase == 2'd2) && !rise;
        cnt_n   = entry_cnt + {6'd0, wr_fire};
    end

    // Download state machine, byte assembly and palette write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= S_IDLE;
            phase            <= 2'd0;
            entry_cnt        <= 7'd0;
            hdr_cnt          <= 8'd0;
            red_q            <= 8'd0;
            grn_q            <= 8'd0;
            act_q            <= 1'b0;
            armed            <= 1'b0;
            load_color       <= 1'b0;
            load_color_data  <= 15'd0;
            load_color_index <= 6'd0;
            busy             <= 1'b0;
            pal_valid        <= 1'b0;
            err_short        <= 1'b0;
        end else begin
            act_q      <= dl_active;
            load_color <= wr_fire;
            if (!dl_active) begin
                armed <= 1'b1;
            end
            if (wr_fire) begin
                load_color_data  <= {dl_data[7:3], grn_q[7:3], red_q[7:3]};
                load_color_index <= entry_cnt[5:0];
            end
            if (rise) begin
                phase     <= 2'd0;
                entry_cnt <= 7'd0;
                hdr_cnt   <= 8'd0;
                pal_valid <= 1'b0;
                err_short <= 1'b0;
                busy      <= 1'b1;
                state     <= HAS_HDR ? S_SKIP : S_RECV;
            end else begin
                case (state)
                    S_SKIP: begin
                        if (dl_wr) begin
                            hdr_cnt <= hdr_cnt + 8'd1;
                            if (hdr_cnt == HDR_LAST) begin
                                state <= S_RECV;
                            end
                        end
                    end
                    S_RECV: begin
                        if (dl_wr) begin
                            case (phase)
                                2'd0: begin
                                    red_q <= dl_data;
                                    phase <= 2'd1;
                                end
                                2'd1: begin
                                    grn_q <= dl_data;
                                    phase <= 2'd2;
                                end
                                default: begin
                                    phase     <= 2'd0;
                                    entry_cnt <= cnt_n;
                                    if (entry_cnt == ENT_LAST) begin
                                        state <= S_DRAIN;
                                    end
                                end
                            endcase
                        end
                    end
                    default: begin
                    end
                endcase
                if (fall && (state != S_IDLE)) begin
                    pal_valid <= (cnt_n == ENT_FULL);
                    err_short <= (cnt_n != ENT_FULL);
                    busy      <= 1'b0;
                    phase     <= 2'd0;
                    state     <= S_IDLE;
                end
            end
        end
    end

endmodule
